// File: rtl/riscv_pkg.sv
// riscv_pkg: shared RISC-V constants, immediate-select encodings and IF fetch FSM states
package riscv_pkg;
  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [2:0] IMM_I = 3'd0;
  localparam logic [2:0] IMM_S = 3'd1;
  localparam logic [2:0] IMM_B = 3'd2;
  localparam logic [2:0] IMM_U = 3'd3;
  localparam logic [2:0] IMM_J = 3'd4;
  localparam logic [2:0] IMM_R = 3'd5;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  typedef enum logic [1:0] {FETCH, HOLD, DROP} if_state_e;
endpackage

// File: rtl/if_predecode.sv
// if_predecode: combinational opcode to immediate-format select; I-format covers all unlisted opcodes
module if_predecode
  import riscv_pkg::*;
(
  input  logic [6:0] opcode,
  output logic [2:0] imm_sel
);
  always_comb
    imm_sel = opcode == OP_STORE  ? IMM_S :
              opcode == OP_BRANCH ? IMM_B :
              (opcode == OP_LUI || opcode == OP_AUIPC) ? IMM_U :
              opcode == OP_JAL    ? IMM_J :
              opcode == OP_OP     ? IMM_R : IMM_I;
endmodule

// File: rtl/if_stage.sv
// if_stage: PC, imem req/ack fetch FSM and IF/ID register.
// Define IF_STAGE_PREDECODE_EN to add the registered if_id_imm_sel output.
module if_stage
  import riscv_pkg::*;
#(
  parameter int XLEN = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int PC_STEP = 4
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [31:0]     imem_rdata,
  input  logic            stall_i,
  input  logic            flush_i,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  output logic            if_id_valid,
  output logic [XLEN-1:0] if_id_pc,
  output logic [XLEN-1:0] if_id_pc4,
  output logic [31:0]     if_id_instr
`ifdef IF_STAGE_PREDECODE_EN
  ,
  output logic [2:0]      if_id_imm_sel
`endif
);
  localparam logic [XLEN-1:0] STEP = XLEN'(PC_STEP);
  if_state_e state, state_n;
  logic [XLEN-1:0] pc_q, pc_n, redir_q, redir_n, hold_pc, ld_pc;
  logic [31:0] hold_instr, ld_instr;
  logic hold_cmd, hold_en, load;
  assign hold_cmd = stall_i | flush_i;
  assign imem_addr = pc_q;
  assign imem_req = !rst && state != HOLD;
  assign ld_pc = state == HOLD ? hold_pc : pc_q;
  assign ld_instr = state == HOLD ? hold_instr : imem_rdata;
  // A request already issued cannot be withdrawn, so a redirect without ack parks in DROP
  always_comb begin
    state_n = state;
    pc_n = pc_q;
    redir_n = redir_q;
    hold_en = 1'b0;
    load = 1'b0;
    case (state)
      FETCH:
        if (redirect_i) begin
          pc_n = imem_ack ? redirect_pc_i : pc_q;
          redir_n = imem_ack ? redir_q : redirect_pc_i;
          state_n = imem_ack ? FETCH : DROP;
        end else if (imem_ack) begin
          pc_n = pc_q + STEP;
          load = !hold_cmd;
          hold_en = hold_cmd;
          state_n = hold_cmd ? HOLD : FETCH;
        end
      DROP:
        if (imem_ack) begin
          pc_n = redirect_i ? redirect_pc_i : redir_q;
          state_n = FETCH;
        end else if (redirect_i) redir_n = redirect_pc_i;
      HOLD:
        if (redirect_i) begin
          pc_n = redirect_pc_i;
          state_n = FETCH;
        end else if (!hold_cmd) begin
          load = 1'b1;
          state_n = FETCH;
        end
      default: state_n = FETCH;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= FETCH;
      pc_q <= RESET_PC;
      redir_q <= '0;
      hold_pc <= '0;
      hold_instr <= NOP;
    end else begin
      state <= state_n;
      pc_q <= pc_n;
      redir_q <= redir_n;
      if (hold_en) begin
        hold_pc <= pc_q;
        hold_instr <= imem_rdata;
      end
    end
  // Flush beats stall; an unstalled cycle without a load presents a bubble
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      if_id_valid <= 1'b0;
      if_id_instr <= NOP;
      if_id_pc <= '0;
      if_id_pc4 <= '0;
    end else if (flush_i) begin
      if_id_valid <= 1'b0;
      if_id_instr <= NOP;
    end else if (!stall_i) begin
      if_id_valid <= load;
      if (load) begin
        if_id_pc <= ld_pc;
        if_id_pc4 <= ld_pc + STEP;
        if_id_instr <= ld_instr;
      end
    end
`ifdef IF_STAGE_PREDECODE_EN
  logic [2:0] ld_imm;
  if_predecode u_predecode (.opcode(ld_instr[6:0]), .imm_sel(ld_imm));
  always_ff @(posedge clk or posedge rst)
    if (rst) if_id_imm_sel <= IMM_I;
    else if (flush_i) if_id_imm_sel <= IMM_I;
    else if (load) if_id_imm_sel <= ld_imm;
`endif
endmodule

// File: tb/tb_if_stage.sv
// tb_if_stage: directed scoreboard bench for if_stage with a variable-latency imem model
module tb_if_stage;
  logic clk, rst, imem_req, imem_ack, stall_i, flush_i, redirect_i, if_id_valid;
  logic [31:0] imem_addr, imem_rdata, redirect_pc_i, if_id_pc, if_id_pc4, if_id_instr;
`ifdef IF_STAGE_PREDECODE_EN
  logic [2:0] if_id_imm_sel;
`endif
  typedef struct {logic [31:0] pc, pc4, instr; logic [2:0] imm;} exp_t;
  exp_t exp_q[$];
  int checks = 0, failures = 0, lat = 1, acks_left = 0;

  if_stage dut (
    .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .stall_i(stall_i), .flush_i(flush_i), .redirect_i(redirect_i),
    .redirect_pc_i(redirect_pc_i), .if_id_valid(if_id_valid), .if_id_pc(if_id_pc),
    .if_id_pc4(if_id_pc4), .if_id_instr(if_id_instr)
`ifdef IF_STAGE_PREDECODE_EN
    , .if_id_imm_sel(if_id_imm_sel)
`endif
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h00: return 32'h0050_0093;
      32'h04: return 32'h00A0_0113;
      32'h40: return 32'hFE00_0EE3;
      32'h44: return 32'h0000_02B7;
      32'h48: return 32'h0000_006F;
      default: return 32'hA000_0000 | a;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push(input logic [31:0] pc, input logic [31:0] pc4, input logic [31:0] instr,
                      input logic [2:0] imm);
    exp_q.push_back('{pc, pc4, instr, imm});
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #3;
  endtask

  task automatic do_reset();
    rst = 1; acks_left = 0; stall_i = 0; flush_i = 0; redirect_i = 0;
    @(posedge clk);
    #3;
    rst = 0;
  endtask

  // imem model: acks after `lat` cycles of req, driven 1 time unit past each edge
  initial begin
    int cnt;
    cnt = 0;
    imem_ack = 0;
    imem_rdata = 0;
    forever begin
      @(posedge clk);
      #1;
      imem_ack = 0;
      if (!rst && imem_req && acks_left > 0) begin
        cnt++;
        if (cnt >= lat) begin
          imem_ack = 1;
          imem_rdata = mem_word(imem_addr);
          acks_left--;
          cnt = 0;
        end
      end else cnt = 0;
    end
  end

  // monitor: ID consumes the IF/ID entry in every valid, unstalled cycle
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && if_id_valid && !stall_i) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_ifid: got pc=%h instr=%h expected none", if_id_pc, if_id_instr);
        end else begin
          e = exp_q.pop_front();
          chk("ifid_pc", if_id_pc, e.pc);
          chk("ifid_pc4", if_id_pc4, e.pc4);
          chk("ifid_instr", if_id_instr, e.instr);
`ifdef IF_STAGE_PREDECODE_EN
          chk("ifid_imm_sel", 32'(if_id_imm_sel), 32'(e.imm));
`endif
        end
      end
    end
  end

  initial begin
    rst = 1; stall_i = 0; flush_i = 0; redirect_i = 0; redirect_pc_i = 0;
    @(posedge clk);
    #3;
    chk("rst_valid", 32'(if_id_valid), 0);
    chk("rst_instr", if_id_instr, 32'h0000_0013);
    chk("rst_pc", if_id_pc, 0);
    chk("rst_pc4", if_id_pc4, 0);
    chk("rst_req", 32'(imem_req), 0);
    chk("rst_addr", imem_addr, 0);
    // single-cycle memory, back-to-back
    lat = 1; acks_left = 3;
    push(0, 4, 32'h0050_0093, 0);
    push(4, 8, 32'h00A0_0113, 0);
    push(8, 12, 32'hA000_0008, 0);
    rst = 0;
    step(2);
    chk("t1_valid0", 32'(if_id_valid), 1);
    chk("t1_pc0", if_id_pc, 0);
    chk("t1_addr4", imem_addr, 4);
    step(1);
    chk("t1_valid1", 32'(if_id_valid), 1);
    chk("t1_pc1", if_id_pc, 4);
    chk("t1_addr8", imem_addr, 8);
    step(6);
    chk("t1_drained", exp_q.size(), 0);
    chk("t1_addr12", imem_addr, 12);
    chk("t1_bubble", 32'(if_id_valid), 0);
    // three-cycle ack latency
    do_reset();
    lat = 3; acks_left = 2;
    push(0, 4, 32'h0050_0093, 0);
    push(4, 8, 32'h00A0_0113, 0);
    for (int i = 0; i < 3; i++) begin
      step(1);
      chk("t2_req_held", 32'(imem_req), 1);
      chk("t2_addr_held", imem_addr, 0);
    end
    chk("t2_ack", 32'(imem_ack), 1);
    step(1);
    chk("t2_load", 32'(if_id_valid), 1);
    step(12);
    chk("t2_drained", exp_q.size(), 0);
    chk("t2_addr8", imem_addr, 8);
    // stall during ack at pc 8
    do_reset();
    lat = 1; acks_left = 4;
    push(0, 4, 32'h0050_0093, 0);
    push(4, 8, 32'h00A0_0113, 0);
    push(8, 12, 32'hA000_0008, 0);
    push(12, 16, 32'hA000_000C, 0);
    step(3);
    stall_i = 1;
    step(1);
    chk("t3_hold_req", 32'(imem_req), 0);
    chk("t3_hold_pc", if_id_pc, 4);
    chk("t3_hold_valid", 32'(if_id_valid), 1);
    step(1);
    stall_i = 0;
    chk("t3_hold_pc2", if_id_pc, 4);
    step(1);
    chk("t3_pc8", if_id_pc, 8);
    chk("t3_addr12", imem_addr, 12);
    step(6);
    chk("t3_drained", exp_q.size(), 0);
    chk("t3_addr16", imem_addr, 16);
    // redirect + flush while fetch at 0x10 is pending
    do_reset();
    lat = 1; acks_left = 4;
    push(0, 4, 32'h0050_0093, 0);
    push(4, 8, 32'h00A0_0113, 0);
    push(8, 12, 32'hA000_0008, 0);
    push(12, 16, 32'hA000_000C, 0);
    step(4);
    lat = 3; acks_left = 1;
    step(2);
    redirect_i = 1; redirect_pc_i = 32'h100; flush_i = 1;
    step(1);
    redirect_i = 0; flush_i = 0;
    chk("t4_flush_valid", 32'(if_id_valid), 0);
    chk("t4_flush_nop", if_id_instr, 32'h0000_0013);
    chk("t4_flush_pc_kept", if_id_pc, 12);
    chk("t4_drop_addr", imem_addr, 32'h10);
    chk("t4_drop_req", 32'(imem_req), 1);
    step(1);
    chk("t4_redir_addr", imem_addr, 32'h100);
    chk("t4_discard", 32'(if_id_valid), 0);
    acks_left = 1;
    push(32'h100, 32'h104, 32'hA000_0100, 0);
    step(10);
    chk("t4_drained", exp_q.size(), 0);
    // two redirects inside DROP, latest wins
    do_reset();
    lat = 3; acks_left = 1;
    step(1);
    redirect_i = 1; redirect_pc_i = 32'h200;
    step(1);
    redirect_pc_i = 32'h300;
    chk("t5_drop_addr", imem_addr, 0);
    chk("t5_drop_req", 32'(imem_req), 1);
    step(1);
    redirect_i = 0;
    chk("t5_drop_addr2", imem_addr, 0);
    step(1);
    chk("t5_latest_wins", imem_addr, 32'h300);
    acks_left = 1;
    push(32'h300, 32'h304, 32'hA000_0300, 0);
    step(8);
    chk("t5_drained", exp_q.size(), 0);
    chk("t5_wait_addr", imem_addr, 32'h304);
    // asynchronous reset mid-wait
    rst = 1;
    #1;
    chk("t5_arst_req", 32'(imem_req), 0);
    chk("t5_arst_addr", imem_addr, 0);
    chk("t5_arst_valid", 32'(if_id_valid), 0);
    chk("t5_arst_instr", if_id_instr, 32'h0000_0013);
    chk("t5_arst_pc", if_id_pc, 0);
    @(posedge clk);
    #3;
    rst = 0;
    #1;
    chk("t5_first_req", 32'(imem_req), 1);
    chk("t5_first_addr", imem_addr, 0);
    // redirect to predecode words, then flush
    do_reset();
    lat = 1;
    step(1);
    redirect_i = 1; redirect_pc_i = 32'h40;
    step(1);
    redirect_i = 0; acks_left = 4;
    push(32'h40, 32'h44, 32'hFE00_0EE3, 3'b010);
    push(32'h44, 32'h48, 32'h0000_02B7, 3'b011);
    push(32'h48, 32'h4C, 32'h0000_006F, 3'b100);
    step(5);
    chk("t6_pc48", if_id_pc, 32'h48);
    chk("t6_instr_j", if_id_instr, 32'h0000_006F);
`ifdef IF_STAGE_PREDECODE_EN
    chk("t6_imm_j", 32'(if_id_imm_sel), 4);
`endif
    flush_i = 1;
    step(1);
    flush_i = 0;
    chk("t6_flush_valid", 32'(if_id_valid), 0);
    chk("t6_flush_nop", if_id_instr, 32'h0000_0013);
    chk("t6_flush_pc_kept", if_id_pc, 32'h48);
`ifdef IF_STAGE_PREDECODE_EN
    chk("t6_flush_imm", 32'(if_id_imm_sel), 0);
`endif
    step(4);
    chk("queue_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
